mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  global enable; low = stall
- in_rollback  in  1  misbranch flush
- in_if_ena  in  1  fetch request pulse
- in_if_addr  in  32  fetch byte address
- out_if_ready  out  1  fetch done pulse
- out_if_data  out  32  fetched word, little-endian
- in_ls_ena  in  1  load/store request pulse
- in_ls_iswrite  in  1  1 = store
- in_ls_addr  in  32  load/store byte address
- in_ls_write_data  in  32  store data, low bytes first
- in_ls_size  in  3  byte count: 1, 2 or 4
- out_ls_ready  out  1  load/store done pulse
- out_ls_read_data  out  32  raw zero-extended load data; sign extension is done by the LS queue
- in_ram_data  in  8  RAM read byte, valid 1 cycle after its address
- out_ram_addr  out  32  RAM byte address
- out_ram_data  out  8  RAM write byte
- out_ram_wr  out  1  RAM write strobe
- in_io_buffer_full  in  1  IO write buffer full

REQ-002 All outputs SHALL be registered.

Function
REQ-003 States SHALL be IDLE, READ and WRITE. A byte counter c (0..4) SHALL track the transfer.
REQ-004 Each requester SHALL have a one-entry pending latch, set by a request pulse and cleared when that transfer starts.
REQ-005 A new LS pulse SHALL overwrite a not-yet-started LS pending entry.
REQ-006 In IDLE, a request present as a pulse on the current edge or as a pending latch SHALL start on that same edge.
REQ-007 Arbitration: LS SHALL beat fetch. A fetch SHALL wait until no LS request is pending.
REQ-008 Fetch SHALL always be a 4-byte read. LS size SHALL be taken from in_ls_size; any value other than 1 or 2 SHALL be treated as 4.
REQ-009 Read, start edge E0: drive out_ram_addr = addr, set c = 1, go to READ.
REQ-010 Read, each later enabled edge:
- capture in_ram_data into result byte c-1;
- if c < n, drive addr+c and increment c.
REQ-011 Read completion: on edge E_n the last byte SHALL be captured, the ready pulse and data registered, and the state SHALL return to IDLE.
REQ-012 Write, start edge E0: drive addr, byte 0 and out_ram_wr = 1, go to WRITE.
REQ-013 Write, each later edge: drive byte c at addr+c, up to n-1.
REQ-014 Write completion: on edge E_n, out_ram_wr = 0, ready pulse registered, return to IDLE.
REQ-015 Ready pulses SHALL be high exactly one cycle. out_if_data and out_ls_read_data SHALL hold their value until the next completion.
REQ-016 Unused upper read bytes SHALL be 0.
REQ-017 IO stall: a write byte whose address has bits [17:16] = 2'b11 SHALL NOT be issued while in_io_buffer_full = 1. During the stall, out_ram_wr = 0 and c is held.
REQ-018 ena low SHALL freeze state, c, latches and out_ram_addr; out_ram_wr = 0 and no ready pulse. On resume, the byte for the held address SHALL be captured.
REQ-019 Rollback SHALL:
- clear the fetch pending latch;
- abort an in-flight fetch to IDLE with no out_if_ready;
- take priority over a fetch pulse on the same edge.
REQ-020 An in-flight or pending LS transfer SHALL be unaffected by rollback and complete normally.
REQ-021 In IDLE, out_ram_addr, out_ram_data and out_ram_wr SHALL be 0.
REQ-022 Address arithmetic SHALL be 32-bit with wrap-around.

Reset
REQ-023 rst SHALL override ena and in_rollback.
REQ-024 On rst the block SHALL go to IDLE, set c = 0, clear both latches, and zero all outputs.
REQ-025 rst SHALL abort any in-flight transfer with no ready pulse.

Verification
REQ-026 Fetch at 0x100, RAM bytes 11 22 33 44 -> out_ram_addr 0x100..0x103 on E0..E3; out_if_ready for one cycle after E4 with out_if_data = 0x44332211.
REQ-027 LS store size 2 at 0x200 with data 0xABCD, same edge as a fetch pulse -> wr bytes CD, AB on E0/E1; out_ls_ready after E2; fetch starts on E2.
REQ-028 LS load size 1 at 0x8, RAM byte 0xF0 -> out_ls_read_data = 0x000000F0 after E1.
REQ-029 Store at 0x30000 with in_io_buffer_full high 3 cycles -> out_ram_wr = 0 for 3 cycles, then byte issued; ready delayed by 3 cycles.
REQ-030 in_rollback on E2 of a fetch -> no out_if_ready; next edge IDLE. Pending LS store completes normally.
REQ-031 rst mid-READ -> all outputs 0 next cycle; a later request runs normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/LS requesters, the arbiter and the byte-wide RAM.
interface mem_arbiter_if;
  // Control
  logic        ena;
  logic        in_rollback;

  // Fetch port
  logic        in_if_ena;
  logic [31:0] in_if_addr;
  logic        out_if_ready;
  logic [31:0] out_if_data;

  // Load/store port
  logic        in_ls_ena;
  logic        in_ls_iswrite;
  logic [31:0] in_ls_addr;
  logic [31:0] in_ls_write_data;
  logic [2:0]  in_ls_size;
  logic        out_ls_ready;
  logic [31:0] out_ls_read_data;

  // RAM / IO side
  logic [7:0]  in_ram_data;
  logic [31:0] out_ram_addr;
  logic [7:0]  out_ram_data;
  logic        out_ram_wr;
  logic        in_io_buffer_full;

  // Arbiter side
  modport slave (
    input  ena,
    input  in_rollback,
    input  in_if_ena,
    input  in_if_addr,
    output out_if_ready,
    output out_if_data,
    input  in_ls_ena,
    input  in_ls_iswrite,
    input  in_ls_addr,
    input  in_ls_write_data,
    input  in_ls_size,
    output out_ls_ready,
    output out_ls_read_data,
    input  in_ram_data,
    output out_ram_addr,
    output out_ram_data,
    output out_ram_wr,
    input  in_io_buffer_full
  );

  // Requester / environment side
  modport master (
    output ena,
    output in_rollback,
    output in_if_ena,
    output in_if_addr,
    input  out_if_ready,
    input  out_if_data,
    output in_ls_ena,
    output in_ls_iswrite,
    output in_ls_addr,
    output in_ls_write_data,
    output in_ls_size,
    input  out_ls_ready,
    input  out_ls_read_data,
    output in_ram_data,
    input  out_ram_addr,
    input  out_ram_data,
    input  out_ram_wr,
    output in_io_buffer_full
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter: load/store beats instruction fetch, one byte per cycle.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned IW = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Pending request latches
  logic            ls_pend_q, ls_pend_d;
  logic            ls_pend_wr_q, ls_pend_wr_d;
  logic [AW-1:0]   ls_pend_addr_q, ls_pend_addr_d;
  logic [DW-1:0]   ls_pend_wdata_q, ls_pend_wdata_d;
  logic [CW-1:0]   ls_pend_n_q, ls_pend_n_d;
  logic            if_pend_q, if_pend_d;
  logic [AW-1:0]   if_pend_addr_q, if_pend_addr_d;

  // In-flight transfer
  logic            cur_ls_q, cur_ls_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [DW-1:0]   cur_wdata_q, cur_wdata_d;
  logic [CW-1:0]   cur_n_q, cur_n_d;
  logic [DW-1:0]   rd_buf_q, rd_buf_d;

  // Registered outputs
  logic            if_ready_q, if_ready_d;
  logic [DW-1:0]   if_data_q, if_data_d;
  logic            ls_ready_q, ls_ready_d;
  logic [DW-1:0]   ls_data_q, ls_data_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [BW-1:0]   ram_data_q, ram_data_d;
  logic            ram_wr_q, ram_wr_d;

  // Combinational helpers
  logic            arb_c;
  logic [IW-1:0]   byte_idx_c;
  logic [AW-1:0]   wr_addr_c;

  // Size code to byte count; anything but 1 or 2 is a word
  function automatic logic [CW-1:0] norm_size(input logic [2:0] s);
    if (s == 3'd1)      return CW'(1);
    else if (s == 3'd2) return CW'(2);
    else                return CW'(4);
  endfunction

  // IO window: writes here are throttled by the IO buffer
  function automatic logic is_io(input logic [AW-1:0] a);
    return a[17:16] == 2'b11;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ls_pend_q       <= 1'b0;
      ls_pend_wr_q    <= 1'b0;
      ls_pend_addr_q  <= '0;
      ls_pend_wdata_q <= '0;
      ls_pend_n_q     <= '0;
      if_pend_q       <= 1'b0;
      if_pend_addr_q  <= '0;
      cur_ls_q        <= 1'b0;
      cur_addr_q      <= '0;
      cur_wdata_q     <= '0;
      cur_n_q         <= '0;
      rd_buf_q        <= '0;
      if_ready_q      <= 1'b0;
      if_data_q       <= '0;
      ls_ready_q      <= 1'b0;
      ls_data_q       <= '0;
      ram_addr_q      <= '0;
      ram_data_q      <= '0;
      ram_wr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ls_pend_q       <= ls_pend_d;
      ls_pend_wr_q    <= ls_pend_wr_d;
      ls_pend_addr_q  <= ls_pend_addr_d;
      ls_pend_wdata_q <= ls_pend_wdata_d;
      ls_pend_n_q     <= ls_pend_n_d;
      if_pend_q       <= if_pend_d;
      if_pend_addr_q  <= if_pend_addr_d;
      cur_ls_q        <= cur_ls_d;
      cur_addr_q      <= cur_addr_d;
      cur_wdata_q     <= cur_wdata_d;
      cur_n_q         <= cur_n_d;
      rd_buf_q        <= rd_buf_d;
      if_ready_q      <= if_ready_d;
      if_data_q       <= if_data_d;
      ls_ready_q      <= ls_ready_d;
      ls_data_q       <= ls_data_d;
      ram_addr_q      <= ram_addr_d;
      ram_data_q      <= ram_data_d;
      ram_wr_q        <= ram_wr_d;
    end
  end

  // Next state: latch requests, step the transfer, arbitrate when free
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ls_pend_d       = ls_pend_q;
    ls_pend_wr_d    = ls_pend_wr_q;
    ls_pend_addr_d  = ls_pend_addr_q;
    ls_pend_wdata_d = ls_pend_wdata_q;
    ls_pend_n_d     = ls_pend_n_q;
    if_pend_d       = if_pend_q;
    if_pend_addr_d  = if_pend_addr_q;
    cur_ls_d        = cur_ls_q;
    cur_addr_d      = cur_addr_q;
    cur_wdata_d     = cur_wdata_q;
    cur_n_d         = cur_n_q;
    rd_buf_d        = rd_buf_q;
    if_data_d       = if_data_q;
    ls_data_d       = ls_data_q;
    ram_addr_d      = ram_addr_q;
    ram_data_d      = ram_data_q;
    ram_wr_d        = 1'b0;
    if_ready_d      = 1'b0;
    ls_ready_d      = 1'b0;
    arb_c           = 1'b0;
    byte_idx_c      = '0;
    wr_addr_c       = '0;

    if (bus.ena) begin
      // A new LS pulse replaces any LS entry that has not started yet
      if (bus.in_ls_ena) begin
        ls_pend_d       = 1'b1;
        ls_pend_wr_d    = bus.in_ls_iswrite;
        ls_pend_addr_d  = bus.in_ls_addr;
        ls_pend_wdata_d = bus.in_ls_write_data;
        ls_pend_n_d     = norm_size(bus.in_ls_size);
      end

      // Rollback kills any fetch request, including one arriving this edge
      if (bus.in_rollback) begin
        if_pend_d = 1'b0;
      end else if (bus.in_if_ena) begin
        if_pend_d      = 1'b1;
        if_pend_addr_d = bus.in_if_addr;
      end

      unique case (state_q)
        IDLE: arb_c = 1'b1;

        READ: begin
          if (!cur_ls_q && bus.in_rollback) begin
            state_d    = IDLE;
            cnt_d      = '0;
            ram_addr_d = '0;
            ram_data_d = '0;
          end else begin
            byte_idx_c = IW'(cnt_q - CW'(1));
            rd_buf_d[{byte_idx_c, 3'b000} +: BW] = bus.in_ram_data;
            if (cnt_q < cur_n_q) begin
              ram_addr_d = cur_addr_q + AW'(cnt_q);
              cnt_d      = cnt_q + CW'(1);
            end else begin
              if (cur_ls_q) begin
                ls_ready_d = 1'b1;
                ls_data_d  = rd_buf_d;
              end else begin
                if_ready_d = 1'b1;
                if_data_d  = rd_buf_d;
              end
              arb_c = 1'b1;
            end
          end
        end

        WRITE: begin
          if (cnt_q < cur_n_q) begin
            byte_idx_c = IW'(cnt_q);
            wr_addr_c  = cur_addr_q + AW'(cnt_q);
            ram_addr_d = wr_addr_c;
            ram_data_d = cur_wdata_q[{byte_idx_c, 3'b000} +: BW];
            if (!(is_io(wr_addr_c) && bus.in_io_buffer_full)) begin
              ram_wr_d = 1'b1;
              cnt_d    = cnt_q + CW'(1);
            end
          end else begin
            ls_ready_d = 1'b1;
            arb_c      = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase

      // Free this edge: start LS first, otherwise fetch, otherwise idle
      if (arb_c) begin
        state_d    = IDLE;
        cnt_d      = '0;
        ram_addr_d = '0;
        ram_data_d = '0;
        ram_wr_d   = 1'b0;
        if (ls_pend_d) begin
          ls_pend_d   = 1'b0;
          cur_ls_d    = 1'b1;
          cur_addr_d  = ls_pend_addr_d;
          cur_wdata_d = ls_pend_wdata_d;
          cur_n_d     = ls_pend_n_d;
          rd_buf_d    = '0;
          ram_addr_d  = ls_pend_addr_d;
          if (ls_pend_wr_d) begin
            state_d    = WRITE;
            ram_data_d = ls_pend_wdata_d[BW-1:0];
            if (is_io(ls_pend_addr_d) && bus.in_io_buffer_full) begin
              cnt_d = '0;
            end else begin
              ram_wr_d = 1'b1;
              cnt_d    = CW'(1);
            end
          end else begin
            state_d = READ;
            cnt_d   = CW'(1);
          end
        end else if (if_pend_d) begin
          if_pend_d   = 1'b0;
          cur_ls_d    = 1'b0;
          cur_addr_d  = if_pend_addr_d;
          cur_wdata_d = '0;
          cur_n_d     = CW'(4);
          rd_buf_d    = '0;
          ram_addr_d  = if_pend_addr_d;
          state_d     = READ;
          cnt_d       = CW'(1);
        end
      end
    end
  end

  assign bus.out_if_ready     = if_ready_q;
  assign bus.out_if_data      = if_data_q;
  assign bus.out_ls_ready     = ls_ready_q;
  assign bus.out_ls_read_data = ls_data_q;
  assign bus.out_ram_addr     = ram_addr_q;
  assign bus.out_ram_data     = ram_data_q;
  assign bus.out_ram_wr       = ram_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a job-level model.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Model state: one in-flight job plus one pending slot per requester
  bit          m_busy, m_ls, m_wr;
  logic [31:0] m_addr, m_wdata;
  int          m_n, m_k;
  bit          p_ls, p_ls_wr;
  logic [31:0] p_ls_addr, p_ls_wdata;
  int          p_ls_n;
  bit          p_if;
  logic [31:0] p_if_addr;
  logic        e_if_ready, e_ls_ready, e_ram_wr;
  logic [31:0] e_if_data, e_ls_data, e_ram_addr;
  logic [7:0]  e_ram_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents as a pure function of address
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0000_0008: return 8'hF0;
      default:       return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  // Synchronous RAM: address is the arbiter's registered output
  always_comb bus.in_ram_data = ram_byte(bus.out_ram_addr);

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r | (32'(ram_byte(a + 32'(i))) << (8 * i));
    return r;
  endfunction

  function automatic int size_bytes(input logic [2:0] s);
    return (s == 3'd1) ? 1 : (s == 3'd2) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Emit the next store byte unless the IO buffer blocks it
  task automatic m_issue();
    logic [31:0] a;
    a = m_addr + 32'(m_k);
    e_ram_addr = a;
    e_ram_data = 8'(m_wdata >> (8 * m_k));
    if (a[17:16] == 2'b11 && bus.in_io_buffer_full) begin
      e_ram_wr = 1'b0;
    end else begin
      e_ram_wr = 1'b1;
      m_k++;
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_step();
    bit free;
    if (rst) begin
      m_busy = 0; p_ls = 0; p_if = 0; m_k = 0;
      e_if_ready = 0; e_ls_ready = 0; e_ram_wr = 0;
      e_if_data = '0; e_ls_data = '0; e_ram_addr = '0; e_ram_data = '0;
      return;
    end
    e_if_ready = 0;
    e_ls_ready = 0;
    e_ram_wr   = 0;
    if (!bus.ena) return;
    if (bus.in_ls_ena) begin
      p_ls = 1; p_ls_wr = bus.in_ls_iswrite; p_ls_addr = bus.in_ls_addr;
      p_ls_wdata = bus.in_ls_write_data; p_ls_n = size_bytes(bus.in_ls_size);
    end
    if (bus.in_rollback) p_if = 0;
    else if (bus.in_if_ena) begin p_if = 1; p_if_addr = bus.in_if_addr; end
    free = !m_busy;
    if (m_busy) begin
      if (!m_ls && bus.in_rollback) begin
        m_busy = 0; e_ram_addr = '0; e_ram_data = '0;
      end else if (m_wr) begin
        if (m_k < m_n) m_issue();
        else begin e_ls_ready = 1; free = 1; end
      end else if (m_k < m_n) begin
        e_ram_addr = m_addr + 32'(m_k);
        m_k++;
      end else begin
        if (m_ls) begin e_ls_ready = 1; e_ls_data = ref_read(m_addr, m_n); end
        else      begin e_if_ready = 1; e_if_data = ref_read(m_addr, m_n); end
        free = 1;
      end
    end
    if (free) begin
      m_busy = 0; e_ram_addr = '0; e_ram_data = '0; e_ram_wr = 0;
      if (p_ls) begin
        p_ls = 0; m_busy = 1; m_ls = 1; m_wr = p_ls_wr;
        m_addr = p_ls_addr; m_wdata = p_ls_wdata; m_n = p_ls_n; m_k = 0;
        if (m_wr) m_issue();
        else begin e_ram_addr = m_addr; m_k = 1; end
      end else if (p_if) begin
        p_if = 0; m_busy = 1; m_ls = 0; m_wr = 0;
        m_addr = p_if_addr; m_wdata = '0; m_n = 4; m_k = 1;
        e_ram_addr = m_addr;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    chk("if_ready", 32'(bus.out_if_ready), 32'(e_if_ready));
    chk("if_data", bus.out_if_data, e_if_data);
    chk("ls_ready", 32'(bus.out_ls_ready), 32'(e_ls_ready));
    chk("ls_data", bus.out_ls_read_data, e_ls_data);
    chk("ram_addr", bus.out_ram_addr, e_ram_addr);
    chk("ram_data", 32'(bus.out_ram_data), 32'(e_ram_data));
    chk("ram_wr", 32'(bus.out_ram_wr), 32'(e_ram_wr));
  endtask

  task automatic quiet();
    rst = 0;
    bus.ena = 1; bus.in_rollback = 0; bus.in_if_ena = 0; bus.in_if_addr = '0;
    bus.in_ls_ena = 0; bus.in_ls_iswrite = 0; bus.in_ls_addr = '0;
    bus.in_ls_write_data = '0; bus.in_ls_size = 3'd4; bus.in_io_buffer_full = 0;
  endtask

  task automatic ls_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    bus.in_ls_ena = 1; bus.in_ls_iswrite = wr; bus.in_ls_addr = a;
    bus.in_ls_write_data = d; bus.in_ls_size = s;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0100 + 32'($urandom_range(0, 15));
      1:       return 32'h0003_0000 + 32'($urandom_range(0, 7));
      2:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      3:       return 32'h0002_FFFE;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    quiet();
    rst = 1;
    step();
    step();
    chk("rst_ram_addr", bus.out_ram_addr, 32'h0);
    chk("rst_ram_wr", 32'(bus.out_ram_wr), 32'h0);
    chk("rst_if_data", bus.out_if_data, 32'h0);
    rst = 0;
    step();

    // Fetch of four bytes at 0x100
    bus.in_if_ena = 1; bus.in_if_addr = 32'h100;
    step(); chk("f_e0_addr", bus.out_ram_addr, 32'h100);
    bus.in_if_ena = 0;
    step(); chk("f_e1_addr", bus.out_ram_addr, 32'h101);
    step(); chk("f_e2_addr", bus.out_ram_addr, 32'h102);
    step(); chk("f_e3_addr", bus.out_ram_addr, 32'h103);
    step(); chk("f_ready", 32'(bus.out_if_ready), 32'h1);
    chk("f_data", bus.out_if_data, 32'h4433_2211);
    step(); chk("f_ready_pulse", 32'(bus.out_if_ready), 32'h0);
    chk("f_data_hold", bus.out_if_data, 32'h4433_2211);

    // Store beats a fetch pulse on the same edge
    ls_req(1, 32'h200, 32'h0000_ABCD, 3'd2);
    bus.in_if_ena = 1; bus.in_if_addr = 32'h100;
    step(); chk("st_e0_data", 32'(bus.out_ram_data), 32'hCD);
    chk("st_e0_wr", 32'(bus.out_ram_wr), 32'h1);
    quiet();
    step(); chk("st_e1_data", 32'(bus.out_ram_data), 32'hAB);
    chk("st_e1_addr", bus.out_ram_addr, 32'h201);
    step(); chk("st_ready", 32'(bus.out_ls_ready), 32'h1);
    chk("st_fetch_start", bus.out_ram_addr, 32'h100);
    repeat (4) step();
    chk("st_fetch_done", 32'(bus.out_if_ready), 32'h1);
    step();

    // Byte load
    ls_req(0, 32'h8, 32'h0, 3'd1);
    step(); quiet();
    step(); chk("ld1_ready", 32'(bus.out_ls_ready), 32'h1);
    chk("ld1_data", bus.out_ls_read_data, 32'h0000_00F0);
    step();

    // IO store held off by a full buffer for three cycles
    ls_req(1, 32'h0003_0000, 32'h0000_0077, 3'd1);
    bus.in_io_buffer_full = 1;
    step(); chk("io_e0_wr", 32'(bus.out_ram_wr), 32'h0);
    bus.in_ls_ena = 0;
    step(); chk("io_e1_wr", 32'(bus.out_ram_wr), 32'h0);
    step(); chk("io_e2_wr", 32'(bus.out_ram_wr), 32'h0);
    bus.in_io_buffer_full = 0;
    step(); chk("io_e3_wr", 32'(bus.out_ram_wr), 32'h1);
    chk("io_e3_data", 32'(bus.out_ram_data), 32'h77);
    step(); chk("io_ready", 32'(bus.out_ls_ready), 32'h1);
    quiet();
    step();

    // Rollback aborts a fetch; a store queued behind it still runs
    bus.in_if_ena = 1; bus.in_if_addr = 32'h100;
    step(); quiet();
    ls_req(1, 32'h40, 32'h0000_005A, 3'd1);
    step(); quiet();
    bus.in_rollback = 1;
    step(); chk("rb_no_ready", 32'(bus.out_if_ready), 32'h0);
    chk("rb_idle_addr", bus.out_ram_addr, 32'h0);
    bus.in_rollback = 0;
    step(); chk("rb_st_addr", bus.out_ram_addr, 32'h40);
    chk("rb_st_wr", 32'(bus.out_ram_wr), 32'h1);
    step(); chk("rb_st_ready", 32'(bus.out_ls_ready), 32'h1);
    repeat (4) begin step(); chk("rb_if_quiet", 32'(bus.out_if_ready), 32'h0); end

    // Reset in the middle of a read, then a clean word load
    bus.in_if_ena = 1; bus.in_if_addr = 32'h104;
    step(); quiet();
    step();
    rst = 1;
    step(); chk("mid_rst_addr", bus.out_ram_addr, 32'h0);
    chk("mid_rst_if_data", bus.out_if_data, 32'h0);
    chk("mid_rst_ls_data", bus.out_ls_read_data, 32'h0);
    rst = 0;
    ls_req(0, 32'h100, 32'h0, 3'd4);
    step(); quiet();
    repeat (4) step();
    chk("post_rst_ready", 32'(bus.out_ls_ready), 32'h1);
    chk("post_rst_data", bus.out_ls_read_data, 32'h4433_2211);
    step();

    // Address wrap across 0xFFFFFFFF
    ls_req(0, 32'hFFFF_FFFE, 32'h0, 3'd4);
    step(); quiet();
    step(); chk("wrap_e1", bus.out_ram_addr, 32'hFFFF_FFFF);
    step(); chk("wrap_e2", bus.out_ram_addr, 32'h0);
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst                  = ($urandom_range(0, 199) == 0);
      bus.ena              = ($urandom_range(0, 9) != 0);
      bus.in_rollback      = ($urandom_range(0, 9) == 0);
      bus.in_if_ena        = ($urandom_range(0, 4) == 0);
      bus.in_if_addr       = pick_addr();
      bus.in_ls_ena        = ($urandom_range(0, 5) == 0);
      bus.in_ls_iswrite    = 1'($urandom_range(0, 1));
      bus.in_ls_addr       = pick_addr();
      bus.in_ls_write_data = $urandom;
      bus.in_ls_size       = 3'($urandom_range(0, 7));
      bus.in_io_buffer_full = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
